// File: rtl/apb_ram_ws_if.sv
// APB4 bus bundle between a master and the wait-state RAM slave.
`timescale 1ns/1ps
interface apb_ram_ws_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_ram_ws.sv
// APB4 slave RAM with per-direction wait states, byte strobes and an
// out-of-range error response. Bus-side outputs depend on registered state only.
`timescale 1ns/1ps
module apb_ram_ws #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int WR_WAIT = 0,
  parameter int RD_WAIT = 0
) (
  input  logic pclk,
  input  logic preset_n,
  apb_ram_ws_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WR_WAIT_C = 4'(WR_WAIT);
  localparam logic [3:0]      RD_WAIT_C = 4'(RD_WAIT);

  // SETUP is a decoded phase: it occupies the cycle in which the master
  // presents psel & ~penable, and its closing edge moves the FSM to ACCESS.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic [3:0]        cnt_q,    cnt_d;
  logic              write_q,  write_d;
  logic              err_q,    err_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [STRB_W-1:0] strb_q,   strb_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic [1:0]        phase_s;
  logic              addr_err_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              mem_we_s;
  logic              pready_s;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Current bus phase as seen by the slave
  always_comb begin
    phase_s = IDLE;
    case (state_q)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          phase_s = SETUP;
        end else begin
          phase_s = IDLE;
        end
      end
      ACCESS:  phase_s = ACCESS;
      default: phase_s = IDLE;
    endcase
  end

  // Address decode and read port sampled at the setup edge
  always_comb begin
    addr_err_s = ({1'b0, bus.paddr} >= DEPTH_C);
    if (addr_err_s) begin
      rd_word_s = {DATA_W{1'b0}};
    end else begin
      rd_word_s = mem[bus.paddr[IDX_W-1:0]];
    end
  end

  // Next-state logic for the transfer FSM and its latched request
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    err_d    = err_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    prdata_d = prdata_q;
    mem_we_s = 1'b0;
    case (phase_s)
      IDLE: begin
        state_d = IDLE;
      end
      SETUP: begin
        state_d = ACCESS;
        write_d = bus.pwrite;
        err_d   = addr_err_s;
        idx_d   = bus.paddr[IDX_W-1:0];
        wdata_d = bus.pwdata;
        strb_d  = bus.pstrb;
        if (bus.pwrite) begin
          cnt_d = WR_WAIT_C;
        end else begin
          cnt_d    = RD_WAIT_C;
          prdata_d = rd_word_s;
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          // master gave up on the transfer: no write, back to idle
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d  = IDLE;
          mem_we_s = write_q & ~err_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control and read-data registers
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= {IDX_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      strb_q   <= {STRB_W{1'b0}};
      prdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      prdata_q <= prdata_d;
    end
  end

  // Byte-masked RAM write; contents are deliberately not reset
  always_ff @(posedge pclk) begin
    if (mem_we_s) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (strb_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign pready_s    = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign bus.pready  = pready_s;
  assign bus.pslverr = pready_s & err_q;
  assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_ram_ws.sv
// Scoreboard bench for apb_ram_ws: three instances with different wait settings
// share one master; a monitor checks every completed transfer against queued expectations.
`timescale 1ns/1ps
module tb_apb_ram_ws;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = 4;

  typedef struct {
    logic          is_rd;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rst2_n;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  int            sel;

  logic          m_pready, m_pslverr;
  logic [DW-1:0] m_prdata;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   start = 0;
  logic [DW-1:0] model [8];

  apb_ram_ws_if #(.ADDR_W(AW), .DATA_W(DW)) if0 (), if1 (), if2 ();

  assign if0.psel = psel & (sel == 0);  assign if0.penable = penable;
  assign if0.pwrite = pwrite;  assign if0.paddr = paddr;
  assign if0.pwdata = pwdata;  assign if0.pstrb = pstrb;
  assign if1.psel = psel & (sel == 1);  assign if1.penable = penable;
  assign if1.pwrite = pwrite;  assign if1.paddr = paddr;
  assign if1.pwdata = pwdata;  assign if1.pstrb = pstrb;
  assign if2.psel = psel & (sel == 2);  assign if2.penable = penable;
  assign if2.pwrite = pwrite;  assign if2.paddr = paddr;
  assign if2.pwdata = pwdata;  assign if2.pstrb = pstrb;

  apb_ram_ws #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(64), .WR_WAIT(0), .RD_WAIT(0))
    dut0 (.pclk(clk), .preset_n(rst_n), .bus(if0));
  apb_ram_ws #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(64), .WR_WAIT(2), .RD_WAIT(3))
    dut1 (.pclk(clk), .preset_n(rst_n), .bus(if1));
  apb_ram_ws #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(64), .WR_WAIT(3), .RD_WAIT(4))
    dut2 (.pclk(clk), .preset_n(rst2_n), .bus(if2));

  always_comb begin
    case (sel)
      1:       begin m_pready = if1.pready; m_pslverr = if1.pslverr; m_prdata = if1.prdata; end
      2:       begin m_pready = if2.pready; m_pslverr = if2.pslverr; m_prdata = if2.prdata; end
      default: begin m_pready = if0.pready; m_pslverr = if0.pslverr; m_prdata = if0.prdata; end
    endcase
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s sel=%0d got=%h want=%h", nm, sel, act, exp);
    end
  endtask

  // Monitor: whenever the selected slave completes, pop and compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (psel && !penable) start = cyc;
      if (m_pready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pready", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", 32'(cyc - start + 1), 32'(e.lat));
          chk("pslverr", {31'd0, m_pslverr}, {31'd0, e.err});
          if (e.is_rd) chk("prdata", m_prdata, e.rdata);
        end
      end
    end
  end

  // One APB transfer; bus left in place so a following call is back-to-back
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input logic [DW-1:0] exp_rd,
                      input logic exp_err, input int wt);
    exp_t e;
    bit   got;
    e.is_rd = !wr; e.rdata = exp_rd; e.err = exp_err; e.lat = 2 + wt;
    exp_q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1 penable = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (m_pready) begin
        got = 1'b1;
      end else begin
        pwdata = $urandom;
        pstrb  = 4'($urandom);
        paddr  = 8'($urandom);
      end
    end
    if (!got) chk("timeout_pready", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < SW; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d, er;
    logic [SW-1:0] s;
    logic          wr, err;

    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'd0; pwdata = 32'd0; pstrb = 4'd0;
    sel = 0; rst_n = 1'b0; rst2_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready0", {31'd0, if0.pready}, 32'd0);
    chk("rst_pslverr0", {31'd0, if0.pslverr}, 32'd0);
    chk("rst_prdata0", if0.prdata, 32'd0);
    chk("rst_pready1", {31'd0, if1.pready}, 32'd0);
    chk("rst_prdata2", if2.prdata, 32'd0);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait write/read, byte strobes, empty strobe
    xfer(1'b1, 8'd5, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, 0);
    xfer(1'b0, 8'd5, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    idle();
    xfer(1'b1, 8'd5, 32'h11223344, 4'b0101, 32'd0, 1'b0, 0);
    idle();
    xfer(1'b0, 8'd5, 32'd0, 4'h0, 32'hDE22BE44, 1'b0, 0);
    xfer(1'b1, 8'd5, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0, 0);
    xfer(1'b0, 8'd5, 32'd0, 4'h0, 32'hDE22BE44, 1'b0, 0);
    idle();

    // out of range: addr 70 aliases word 6 if the range check is missing
    xfer(1'b1, 8'd6, 32'h66666666, 4'hF, 32'd0, 1'b0, 0);
    xfer(1'b1, 8'd63, 32'h0BADF00D, 4'hF, 32'd0, 1'b0, 0);
    xfer(1'b1, 8'd70, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1, 0);
    xfer(1'b0, 8'd6, 32'd0, 4'h0, 32'h66666666, 1'b0, 0);
    xfer(1'b0, 8'd63, 32'd0, 4'h0, 32'h0BADF00D, 1'b0, 0);
    xfer(1'b0, 8'd70, 32'd0, 4'h0, 32'd0, 1'b1, 0);
    idle();

    // wait states on the second instance; bus inputs scrambled during waits
    sel = 1;
    xfer(1'b1, 8'd9, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0, 2);
    idle();
    xfer(1'b0, 8'd9, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0, 3);
    xfer(1'b1, 8'd9, 32'h5A000000, 4'b1000, 32'd0, 1'b0, 2);
    xfer(1'b0, 8'd9, 32'd0, 4'h0, 32'h5AA5A5A5, 1'b0, 3);
    idle();

    // back-to-back traffic against a word model
    sel = 0;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      model[i] = d;
      xfer(1'b1, 8'(i), d, 4'hF, 32'd0, 1'b0, 0);
    end
    for (int k = 0; k < 30; k++) begin
      wr  = 1'($urandom);
      a   = (k % 7 == 6) ? 8'(64 + k) : 8'($urandom_range(0, 7));
      d   = $urandom;
      s   = 4'($urandom);
      err = (a >= 8'd64);
      er  = err ? 32'd0 : model[a[2:0]];
      if (wr && !err) model[a[2:0]] = merge(model[a[2:0]], d, s);
      xfer(wr, a, d, s, wr ? 32'd0 : er, err, 0);
    end
    for (int i = 0; i < 8; i++) xfer(1'b0, 8'(i), 32'd0, 4'h0, model[i], 1'b0, 0);
    idle();

    // abort by dropping psel in the second ACCESS cycle
    sel = 2;
    xfer(1'b1, 8'd3, 32'h12345678, 4'hF, 32'd0, 1'b0, 3);
    idle();
    xfer(1'b0, 8'd3, 32'd0, 4'h0, 32'h12345678, 1'b0, 4);
    idle();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'd3;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("abort_acc1_pready", {31'd0, m_pready}, 32'd0);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_pready", {31'd0, m_pready}, 32'd0);
    end
    @(posedge clk); #1;
    xfer(1'b0, 8'd3, 32'd0, 4'h0, 32'h12345678, 1'b0, 4);
    idle();

    // reset during write wait states
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    rst2_n = 1'b0;
    #1;
    chk("rst_mid_pready", {31'd0, if2.pready}, 32'd0);
    chk("rst_mid_pslverr", {31'd0, if2.pslverr}, 32'd0);
    chk("rst_mid_prdata", if2.prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst2_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 8'd3, 32'd0, 4'h0, 32'h12345678, 1'b0, 4);
    idle();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
